// File: rtl/clock_meter_pkg.sv
// Shared types and default constants for the clock period meter.
package clock_meter_pkg;

  typedef enum logic {
    ARM     = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int          CNT_WIDTH_DEF  = 27;
  localparam int unsigned PERIOD_MIN_DEF = 99_990_000;
  localparam int unsigned PERIOD_MAX_DEF = 100_010_000;

`ifdef SIMULATION
  // Short period used by simulation builds in place of the 1 Hz divided clock.
  localparam int SIM_PERIOD = 10;
`endif

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes the slow asynchronous input into the 100 MHz domain and
// flags its rising and falling edges for one cycle each.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clock_100MHz,
  input  logic Clear,
  input  logic Clock_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p;
  logic                   s;

  always_ff @(posedge Clock_100MHz) begin
    if (Clear) begin
      sync_q <= '0;
      p      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Clock_in};
      p      <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~p;
  assign fall = ~s & p;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous clock in Clock_100MHz
// cycles and hands each result to a consumer over a valid/ready port.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int          CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int          SYNC_STAGES = 2,
  parameter int unsigned PERIOD_MIN  = PERIOD_MIN_DEF,
  parameter int unsigned PERIOD_MAX  = PERIOD_MAX_DEF
) (
  input  logic                 Clock_100MHz,
  input  logic                 Clear,
  input  logic                 Clock_in,
  output logic [CNT_WIDTH-1:0] Period,
  output logic [CNT_WIDTH-1:0] High_time,
  output logic                 In_range,
  output logic                 Valid,
  input  logic                 Ready,
  output logic                 Timeout,
  output logic                 Overrun,
  output logic                 Fsm_state
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] hi;
  logic                 rise;
  logic                 fall;
  logic                 range_ok;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .Clock_100MHz(Clock_100MHz),
    .Clear       (Clear),
    .Clock_in    (Clock_in),
    .rise        (rise),
    .fall        (fall)
  );

  assign range_ok  = (64'(cnt) >= 64'(PERIOD_MIN)) && (64'(cnt) <= 64'(PERIOD_MAX));
  assign Fsm_state = state;

  // Handshake: a result transfers on any cycle with Valid && Ready. While Valid
  // is high and not accepted, Period/High_time/In_range hold. A publish in an
  // accepting cycle reloads and keeps Valid; a publish into an unaccepted
  // result is dropped and raises the sticky Overrun.
  always_ff @(posedge Clock_100MHz) begin
    if (Clear) begin
      state     <= ARM;
      cnt       <= '0;
      hi        <= '0;
      Period    <= '0;
      High_time <= '0;
      In_range  <= 1'b0;
      Valid     <= 1'b0;
      Timeout   <= 1'b0;
      Overrun   <= 1'b0;
    end else begin
      if (Valid && Ready) Valid <= 1'b0;
      case (state)
        ARM: begin
          if (rise) begin
            cnt   <= CNT_ONE;
            hi    <= '0;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            if (!Valid || Ready) begin
              Period    <= cnt;
              High_time <= hi;
              In_range  <= range_ok;
              Valid     <= 1'b1;
            end else begin
              Overrun <= 1'b1;
            end
            cnt <= CNT_ONE;
            hi  <= '0;
          end else if (cnt == '1) begin
            // Saturated with no edge: give up and wait for a fresh arming rise.
            Timeout <= 1'b1;
            cnt     <= '0;
            hi      <= '0;
            state   <= ARM;
          end else begin
            cnt <= cnt + CNT_ONE;
            if (fall) hi <= cnt;
          end
        end
        default: state <= ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: three parameterisations driven by one stimulus
// stream, compared every cycle against an edge-timestamp model.
module tb_clock_period_meter;

  localparam int SS = 2;

  logic clk = 1'b0;
  logic Clear = 1'b1;
  logic Clock_in = 1'b0;
  logic Ready = 1'b1;

  always #5 clk = ~clk;

  logic [26:0] per_a, hi_a, per_b, hi_b;
  logic [3:0]  per_c, hi_c;
  logic ir_a, val_a, to_a, ov_a, st_a;
  logic ir_b, val_b, to_b, ov_b, st_b;
  logic ir_c, val_c, to_c, ov_c, st_c;

  clock_period_meter u_a (
    .Clock_100MHz(clk), .Clear(Clear), .Clock_in(Clock_in),
    .Period(per_a), .High_time(hi_a), .In_range(ir_a), .Valid(val_a),
    .Ready(Ready), .Timeout(to_a), .Overrun(ov_a), .Fsm_state(st_a)
  );

  clock_period_meter #(.PERIOD_MIN(9), .PERIOD_MAX(11)) u_b (
    .Clock_100MHz(clk), .Clear(Clear), .Clock_in(Clock_in),
    .Period(per_b), .High_time(hi_b), .In_range(ir_b), .Valid(val_b),
    .Ready(Ready), .Timeout(to_b), .Overrun(ov_b), .Fsm_state(st_b)
  );

  clock_period_meter #(.CNT_WIDTH(4), .PERIOD_MIN(9), .PERIOD_MAX(11)) u_c (
    .Clock_100MHz(clk), .Clear(Clear), .Clock_in(Clock_in),
    .Period(per_c), .High_time(hi_c), .In_range(ir_c), .Valid(val_c),
    .Ready(Ready), .Timeout(to_c), .Overrun(ov_c), .Fsm_state(st_c)
  );

  logic [26:0] act_per[3];
  logic [26:0] act_hi[3];
  logic        act_ir[3], act_val[3], act_to[3], act_ov[3], act_st[3];

  assign act_per[0] = per_a;
  assign act_per[1] = per_b;
  assign act_per[2] = {23'b0, per_c};
  assign act_hi[0]  = hi_a;
  assign act_hi[1]  = hi_b;
  assign act_hi[2]  = {23'b0, hi_c};
  assign act_ir[0]  = ir_a;
  assign act_ir[1]  = ir_b;
  assign act_ir[2]  = ir_c;
  assign act_val[0] = val_a;
  assign act_val[1] = val_b;
  assign act_val[2] = val_c;
  assign act_to[0]  = to_a;
  assign act_to[1]  = to_b;
  assign act_to[2]  = to_c;
  assign act_ov[0]  = ov_a;
  assign act_ov[1]  = ov_b;
  assign act_ov[2]  = ov_c;
  assign act_st[0]  = st_a;
  assign act_st[1]  = st_b;
  assign act_st[2]  = st_c;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // ---------------- model: edge timestamps, not counters ----------------
  int     cw[3]   = '{27, 27, 4};
  longint pmin[3] = '{99_990_000, 9, 9};
  longint pmax[3] = '{100_010_000, 11, 11};

  bit x_hist[0:8191];
  bit c_hist[0:8191];
  int k = -1;
  bit m_init = 1'b0;

  bit     m_armed[3], m_fseen[3];
  longint m_trise[3], m_tfall[3], m_per[3], m_hi[3];
  bit     m_ir[3], m_val[3], m_to[3], m_ov[3];

  // Synchronized level after edge j: input from SS-1 edges earlier unless a
  // Clear wiped the synchronizer in between.
  function automatic bit s_of(input int j);
    if (j - SS + 1 < 0) return 1'b0;
    for (int i = j - SS + 2; i <= j; i++) if (c_hist[i]) return 1'b0;
    return x_hist[j-SS+1];
  endfunction

  function automatic bit p_of(input int j);
    if (j < 0 || c_hist[j]) return 1'b0;
    return s_of(j - 1);
  endfunction

  always @(posedge clk) begin : model
    bit r, f;
    k++;
    x_hist[k] = Clear ? 1'b0 : Clock_in;
    c_hist[k] = Clear;
    r = s_of(k-1) & ~p_of(k-1);
    f = ~s_of(k-1) & p_of(k-1);
    if (Clear) m_init = 1'b1;
    for (int i = 0; i < 3; i++) begin : step
      longint el, all1;
      bit old_v;
      all1  = (longint'(1) << cw[i]) - 1;
      old_v = m_val[i];
      if (Clear) begin
        m_armed[i] = 0; m_fseen[i] = 0; m_per[i] = 0; m_hi[i] = 0;
        m_ir[i] = 0; m_val[i] = 0; m_to[i] = 0; m_ov[i] = 0;
      end else begin
        if (m_val[i] && Ready) m_val[i] = 0;
        if (!m_armed[i]) begin
          if (r) begin
            m_armed[i] = 1; m_trise[i] = k; m_fseen[i] = 0;
          end
        end else begin
          el = k - m_trise[i];
          if (r) begin
            if (!old_v || Ready) begin
              m_per[i] = el;
              m_hi[i]  = m_fseen[i] ? (m_tfall[i] - m_trise[i]) : 0;
              m_ir[i]  = (el >= pmin[i]) && (el <= pmax[i]);
              m_val[i] = 1;
            end else begin
              m_ov[i] = 1;
            end
            m_trise[i] = k; m_fseen[i] = 0;
          end else if (el == all1) begin
            m_to[i] = 1; m_armed[i] = 0;
          end else if (f) begin
            m_tfall[i] = k; m_fseen[i] = 1;
          end
        end
      end
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_init) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("period[%0d]", i),    act_per[i], m_per[i]);
        chk($sformatf("high_time[%0d]", i), act_hi[i],  m_hi[i]);
        chk($sformatf("in_range[%0d]", i),  act_ir[i],  m_ir[i]);
        chk($sformatf("valid[%0d]", i),     act_val[i], m_val[i]);
        chk($sformatf("timeout[%0d]", i),   act_to[i],  m_to[i]);
        chk($sformatf("overrun[%0d]", i),   act_ov[i],  m_ov[i]);
        chk($sformatf("state[%0d]", i),     act_st[i],  m_armed[i]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic square(input int per, input int hi);
    Clock_in = 1'b1;
    repeat (hi) @(negedge clk);
    Clock_in = 1'b0;
    repeat (per - hi) @(negedge clk);
  endtask

  task automatic expect_result(input string name, input longint p, input longint h,
                               input bit ira, input bit irb);
    int n = 0;
    while (act_val[0] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (act_val[0] !== 1'b1) begin
      chk({name, "_valid_wait"}, act_val[0], 1);
      return;
    end
    chk({name, "_period"},   act_per[0], p);
    chk({name, "_high"},     act_hi[0],  h);
    chk({name, "_ir_a"},     act_ir[0],  ira);
    chk({name, "_ir_b"},     act_ir[1],  irb);
    chk({name, "_m_period"}, m_per[0],   p);
    chk({name, "_m_high"},   m_hi[0],    h);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string name, input int i);
    chk({name, "_per"}, act_per[i], 0);
    chk({name, "_hi"},  act_hi[i],  0);
    chk({name, "_ir"},  act_ir[i],  0);
    chk({name, "_val"}, act_val[i], 0);
    chk({name, "_to"},  act_to[i],  0);
    chk({name, "_ov"},  act_ov[i],  0);
    chk({name, "_st"},  act_st[i],  0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    // Reset
    @(negedge clk);
    chk_zero("reset_a", 0);
    chk_zero("reset_c", 2);
    @(negedge clk);
    Clear = 1'b0;
    @(negedge clk);

    // 10-cycle wave, 5 high, Ready tied high
    fork
      repeat (4) square(10, 5);
      begin
        expect_result("wave10_r1", 10, 5, 1'b0, 1'b1);
        expect_result("wave10_r2", 10, 5, 1'b0, 1'b1);
      end
    join

    // Long low: only the 4-bit instance saturates
    Clock_in = 1'b0;
    repeat (20) @(negedge clk);
    chk("to_c_set",   act_to[2],  1);
    chk("to_c_state", act_st[2],  0);
    chk("to_c_valid", act_val[2], 0);
    chk("to_a_clear", act_to[0],  0);
    repeat (3) square(10, 5);
    chk("resume_c_period", act_per[2], 10);
    chk("resume_c_high",   act_hi[2],  5);
    chk("resume_c_sticky", act_to[2],  1);
    chk("resume_c_state",  act_st[2],  1);

    // Ready low across three periods
    Ready = 1'b0;
    repeat (3) square(10, 5);
    chk("hold_valid",   act_val[0], 1);
    chk("hold_period",  act_per[0], 10);
    chk("hold_high",    act_hi[0],  5);
    chk("hold_overrun", act_ov[0],  1);
    Ready = 1'b1;
    @(negedge clk);
    chk("accept_drop", act_val[0], 0);
    repeat (3) @(negedge clk);

    // Ready raised exactly on a publish cycle
    Clear = 1'b1;
    @(negedge clk);
    Clear = 1'b0;
    Ready = 1'b0;
    @(negedge clk);
    square(12, 4);
    square(10, 5);
    Clock_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_period", act_per[0], 12);
    chk("pre_high",   act_hi[0],  4);
    chk("pre_valid",  act_val[0], 1);
    Ready = 1'b1;
    @(negedge clk);
    Ready = 1'b0;
    chk("same_cycle_period",  act_per[0], 10);
    chk("same_cycle_high",    act_hi[0],  5);
    chk("same_cycle_valid",   act_val[0], 1);
    chk("same_cycle_overrun", act_ov[0],  0);
    repeat (2) @(negedge clk);
    Clock_in = 1'b0;
    Ready = 1'b1;
    repeat (5) @(negedge clk);

    // Clear mid-period with Clock_in high
    repeat (2) square(10, 5);
    Clock_in = 1'b1;
    repeat (3) @(negedge clk);
    Clear = 1'b1;
    @(negedge clk);
    Clear = 1'b0;
    chk_zero("midclear_a", 0);
    chk_zero("midclear_c", 2);
    repeat (3) @(negedge clk);
    Clock_in = 1'b0;
    vcnt = 0;
    repeat (8) begin
      @(negedge clk);
      vcnt += int'(act_val[0]);
    end
    chk("midclear_no_publish", vcnt, 0);
    chk("midclear_armed", act_st[0], 1);
    repeat (2) square(10, 5);

    // Duty-cycle sweep at 12-cycle period
    fork
      begin
        square(12, 1);
        square(12, 6);
        square(12, 11);
        square(12, 1);
      end
      begin
        expect_result("sweep_prev", 10, 5, 1'b0, 1'b1);
        expect_result("sweep_h1",   12, 1, 1'b0, 1'b0);
        expect_result("sweep_h6",   12, 6, 1'b0, 1'b0);
        expect_result("sweep_h11",  12, 11, 1'b0, 1'b0);
      end
    join

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_period_meter.md
# clock_period_meter

Measures the period and high time of a slow, asynchronous square-wave input, such as the 1 Hz divided clock, in units of `Clock_100MHz` cycles. Each completed measurement is presented on a valid/ready output port for the APB counter IP and the verification monitors. Each result also carries a pass/fail range check against programmable limits, plus sticky timeout and overrun flags.

## Interface
- `CNT_WIDTH`, 27, width of the cycle counter and of the result fields (must hold 100,000,000).
- `SYNC_STAGES`, 2, number of synchronizer flops on `Clock_in` (minimum 2).
- `PERIOD_MIN`, 99_990_000, lowest period, inclusive, that sets `In_range`.
- `PERIOD_MAX`, 100_010_000, highest period, inclusive, that sets `In_range`.

- `Clock_100MHz` in 1: the single clock; every flop is on its rising edge.
- `Clear` in 1: synchronous, active-high reset.
- `Clock_in` in 1: the asynchronous slow clock being measured.
- `Period` out CNT_WIDTH: cycles between consecutive detected rising edges.
- `High_time` out CNT_WIDTH: cycles from a detected rise to the following detected fall.
- `In_range` out 1: `PERIOD_MIN <= Period <= PERIOD_MAX`; valid only while `Valid` is high.
- `Valid` out 1: result fields hold a measurement that has not yet been accepted.
- `Ready` in 1: consumer accepts the result.
- `Timeout` out 1: sticky; the counter saturated with no rising edge.
- `Overrun` out 1: sticky; a measurement completed while the previous one was still unaccepted.

## Operation
- The synchronizer output `s` feeds a registered copy `p`.
  - `rise = s & ~p`
  - `fall = ~s & p`
- FSM states:
  - `ARM`: wait for the first rise. On `rise`: `cnt <= 1`, go to `MEASURE`. No result is produced.
  - `MEASURE`:
    - `cnt` increments each cycle.
    - On `fall`: `hi <= cnt`.
    - On `rise`: publish `Period <= cnt`, `High_time <= hi`, and `In_range`. Then `cnt <= 1` and stay in `MEASURE`.
    - If `cnt` equals all-ones and there is no `rise`: set `Timeout`, go to `ARM`, publish nothing.
- Counting arithmetic:
  - `cnt` is unsigned, CNT_WIDTH bits, and never wraps.
  - `Period = k` exactly when the two detected rises are k cycles apart.
- If no `fall` occurs between two rises, the published `High_time` is 0.
- Handshake:
  - A result is accepted on a cycle where `Valid && Ready`.
  - Result fields and `In_range` stay stable while `Valid` is high and not accepted.
- Acceptance and a new publish in the same cycle: the new result loads, `Valid` stays 1, and no overrun is flagged.
- Publish while `Valid && !Ready`:
  - The new result is dropped and the old result is kept.
  - `Overrun` is set.
  - Counting continues, with `cnt <= 1`.
- `Timeout` and `Overrun` clear only on `Clear`.

## Timing
- `Clear` sampled high produces, on the next edge:
  - FSM = `ARM`; `cnt`, `hi`, synchronizer flops and `p` all 0.
  - `Period = 0`, `High_time = 0`, `In_range = 0`, `Valid = 0`, `Timeout = 0`, `Overrun = 0`.
- `Clear` overrides every other event in the same cycle.
- Asserting `Clear` mid-measurement discards the partial count; no result is published.
- `Clock_in` held high through `Clear`: the first `rise` appears after the synchronizer fills (SYNC_STAGES + 1 edges). That rise only arms the FSM.
- Latency: with `Clock_in` rising before edge E1, `rise` is high during the cycle after edge E(SYNC_STAGES). `Valid`, `Period` and `In_range` update at edge E(SYNC_STAGES+1), i.e. E3 for the default.
- A single-cycle input pulse shorter than one period may be missed; the minimum measurable `Period` is 2.

## Structure
- Shared package `clock_meter_pkg` holds:
  - the state enum (`ARM`, `MEASURE`);
  - the default `CNT_WIDTH`, `PERIOD_MIN` and `PERIOD_MAX` constants;
  - a `SIM_PERIOD` constant of 10 cycles for `SIMULATION` builds.
- One sub-module, `sync_edge_detect`, contains:
  - the SYNC_STAGES synchronizer with reset-to-0 flops;
  - the `p` register;
  - the `rise`/`fall` outputs.
- The top level holds the FSM, `cnt`/`hi`, the result registers, the range compare and the flags.

## Test plan
- Square wave, 10-cycle period, 5 high, `Ready` tied 1: the first result (after the arming rise) is `Period = 10`, `High_time = 5`, `Valid` high for 1 cycle every 10 cycles; `In_range = 0` with default limits, `In_range = 1` with `PERIOD_MIN = 9`, `PERIOD_MAX = 11`.
- `CNT_WIDTH = 4`, `Clock_in` held low after arming: `Timeout` rises when `cnt = 15`, FSM returns to `ARM`, no `Valid`; a later 10-cycle wave resumes measurement.
- `Ready` held 0 across three periods: the first result is held unchanged, `Overrun = 1` after the second rise; `Ready = 1` then yields one accept and `Valid` drops the next cycle.
- `Ready` asserted exactly on a publish cycle: new values load, `Valid` stays 1, `Overrun` stays 0.
- `Clear` pulsed mid-period: every output reads 0 on the next edge, and the next rise only arms the FSM with no publish.
- Duty-cycle sweep with a 12-cycle period and high times 1, 6 and 11: `High_time` reads 1, 6 and 11, and `Period` always reads 12.
